relu_array: RTL and testbench
=============================

// Module: relu_array
// PURPOSE
//   Multi-lane, mode-selectable activation stage between the accumulator/requant path and the output
//   buffer. Applies bypass, ReLU, leaky ReLU or clamped ReLU to LANES signed fixed-point values per beat.
//   Uses a 2-stage stallable pipeline with valid/ready handshakes on both sides and frame-end tagging.
// PARAMETERS
//   NUM_WIDTH   16  width of each signed two's-complement element
//   LANES       4   elements per beat
//   FRAC_BITS   8   fractional bits; clamp ceiling = 6.0 = 6<<FRAC_BITS, saturated to max positive
//   STAT_WIDTH  32  width of the negative-element counter (RELU_STATS_EN only)
// PORTS
//   clk        in   1                clock; all logic on posedge
//   rst_n      in   1                asynchronous, active-low reset
//   mode       in   2                activation select, sampled with each accepted beat
//   leaky_sh   in   4                leaky right-shift amount, sampled with each accepted beat
//   up_valid   in   1                upstream beat valid
//   up_ready   out  1                block can accept a beat
//   up_data    in   LANES*NUM_WIDTH  lane i = bits [i*NUM_WIDTH +: NUM_WIDTH]
//   up_last    in   1                last beat of frame
//   dn_valid   out  1                output beat valid
//   dn_ready   in   1                downstream accepts
//   dn_data    out  LANES*NUM_WIDTH  activated lanes
//   dn_last    out  1                up_last delayed with its beat
//   neg_count  out  STAT_WIDTH       negative elements seen in the current frame (RELU_STATS_EN only)
// BEHAVIOUR
//   - Reset: dn_valid=0, dn_data=0, dn_last=0, neg_count=0, both stage valids=0.
//     up_ready is 1 while rst_n is high and no stall is in progress.
//   - Modes: 00 BYPASS (x). 01 RELU (x<0 -> 0). 10 LEAKY (x<0 -> x>>>leaky_sh, arithmetic shift).
//     11 CLAMP: x<0 -> 0; x>6.0 -> 6.0; else x. If 6.0 exceeds the positive range, the ceiling is
//     2^(NUM_WIDTH-1)-1.
//   - Sign test uses the MSB. The value 0 is non-negative. LEAKY with leaky_sh=0 behaves as BYPASS.
//   - Pipeline: S1 registers the input, mode, leaky_sh and last. S2 registers the activated result.
//     Latency is 2 cycles from up_valid&&up_ready to dn_valid with no backpressure.
//     Full throughput is 1 beat/cycle.
//   - Handshake: a transfer happens on valid&&ready.
//     up_ready = !s1_valid || (!s2_valid || dn_ready), so S1 can advance whenever S2 frees.
//     It is combinational from dn_ready and has no combinational path from up_valid.
//   - dn_valid, once high, stays high and dn_data/dn_last stay stable until dn_ready. AXI-stream rules.
//   - A mode change mid-stream affects only beats accepted after the change.
//   - Reset mid-operation drops all in-flight beats immediately. No partial beat is emitted.
// CONFIGURATION
//   RELU_STATS_EN defined: neg_count increments by the number of negative lanes (0..LANES) in each
//     beat leaving S2. It wraps modulo 2^STAT_WIDTH. On the dn_last beat it loads that beat's count,
//     so it holds the finished frame's count during that beat's handshake; it clears on the next beat.
//   RELU_STATS_EN undefined: neg_count is tied to 0. No counter or popcount logic is built.
// STRUCTURE
//   relu_pkg: mode localparams (RELU_MODE_BYPASS/RELU/LEAKY/CLAMP) and the clamp-ceiling function.
//   Sub-module relu_lane: combinational, one element with mode and shift -> result and is_neg.
//     relu_array instantiates it LANES times with generate.
//   relu_array owns the pipeline registers, the handshake and the optional counter.
// TESTING
//   1 Reset release, RELU, LANES=4, beat {0x8000,0xFFFF,0x0000,0x7FFF} -> dn {0,0,0,0x7FFF}
//     two cycles later.
//   2 LEAKY, sh=2, lane 0xFFF0 (-16) -> 0xFFFC (-4). BYPASS passes 0xFFF0 unchanged.
//   3 CLAMP, FRAC_BITS=8, {0x0700,0x0600,0x05FF,0xFF00} -> {0x0600,0x0600,0x05FF,0x0000}.
//   4 Back-to-back 8 beats with dn_ready toggling 1010... -> all 8 beats in order, none dropped or
//     duplicated; dn_data stable while stalled.
//   5 Mode switched RELU->BYPASS between beats 3 and 4 -> beats 0-3 rectified, 4+ raw.
//     rst_n low mid-stream -> dn_valid=0 the same cycle.
//   6 RELU_STATS_EN, 2-beat frame with 3 and 1 negative lanes -> neg_count=4 at the dn_last handshake,
//     then 0 or the next beat's count.

Source files
------------

// File: rtl/relu_pkg.sv
// Shared mode encodings and the clamp-ceiling helper for the activation stage.
// Both relu_lane and relu_array import this package.
package relu_pkg;

    localparam logic [1:0] RELU_MODE_BYPASS = 2'b00;
    localparam logic [1:0] RELU_MODE_RELU   = 2'b01;
    localparam logic [1:0] RELU_MODE_LEAKY  = 2'b10;
    localparam logic [1:0] RELU_MODE_CLAMP  = 2'b11;

    // The ceiling is 6.0 in the element's fixed-point format.
    // It saturates to the largest positive value when 6.0 cannot be represented.
    function automatic longint clamp_ceiling(input int num_width, input int frac_bits);
        longint ceil6;
        longint maxpos;
        ceil6  = longint'(6) << frac_bits;
        maxpos = (longint'(1) << (num_width - 1)) - 1;
        return (ceil6 > maxpos) ? maxpos : ceil6;
    endfunction

endpackage

// File: rtl/relu_lane.sv
// Combinational activation of one signed element: bypass, ReLU, leaky ReLU or clamped ReLU.
// Zero latency, no handshake; is_neg reports the input sign for the optional frame statistics.
module relu_lane
    import relu_pkg::*;
#(
    parameter int NUM_WIDTH = 16,
    parameter int FRAC_BITS = 8
) (
    input  logic [NUM_WIDTH-1:0] x,
    input  logic [1:0]           mode,
    input  logic [3:0]           sh,
    output logic [NUM_WIDTH-1:0] y,
    output logic                 is_neg
);

    localparam logic signed [NUM_WIDTH-1:0] CEIL =
        NUM_WIDTH'(clamp_ceiling(NUM_WIDTH, FRAC_BITS));

    logic signed [NUM_WIDTH-1:0] xs;
    assign xs     = x;
    assign is_neg = x[NUM_WIDTH-1];

    always_comb begin
        y = x;
        case (mode)
            RELU_MODE_BYPASS: y = x;
            RELU_MODE_RELU: begin
                if (is_neg) y = '0;
            end
            RELU_MODE_LEAKY: begin
                if (is_neg) y = xs >>> sh;
            end
            RELU_MODE_CLAMP: begin
                if (is_neg)         y = '0;
                else if (xs > CEIL) y = CEIL;
            end
        endcase
    end

endmodule

// File: rtl/relu_array.sv
// Multi-lane activation stage: two-stage stallable valid/ready pipeline, latency 2 cycles, 1 beat/cycle.
// up_ready = !s1_valid || !s2_valid || dn_ready. RELU_STATS_EN builds the per-frame negative-element counter.
module relu_array
    import relu_pkg::*;
#(
    parameter int NUM_WIDTH  = 16,
    parameter int LANES      = 4,
    parameter int FRAC_BITS  = 8,
    parameter int STAT_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [1:0]                 mode,
    input  logic [3:0]                 leaky_sh,
    input  logic                       up_valid,
    output logic                       up_ready,
    input  logic [LANES*NUM_WIDTH-1:0] up_data,
    input  logic                       up_last,
    output logic                       dn_valid,
    input  logic                       dn_ready,
    output logic [LANES*NUM_WIDTH-1:0] dn_data,
    output logic                       dn_last,
    output logic [STAT_WIDTH-1:0]      neg_count
);

    logic                       s1_valid;
    logic [LANES*NUM_WIDTH-1:0] s1_data;
    logic [1:0]                 s1_mode;
    logic [3:0]                 s1_sh;
    logic                       s1_last;

    logic                       s2_valid;
    logic [LANES*NUM_WIDTH-1:0] s2_data;
    logic                       s2_last;

    logic                       s2_adv;
    logic                       s1_adv;
    logic [LANES*NUM_WIDTH-1:0] act_bus;
    logic [LANES-1:0]           lane_neg;

    assign s2_adv   = !s2_valid || dn_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign up_ready = s1_adv;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_mode  <= RELU_MODE_BYPASS;
            s1_sh    <= '0;
            s1_last  <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= up_valid;
            if (up_valid) begin
                s1_data <= up_data;
                s1_mode <= mode;
                s1_sh   <= leaky_sh;
                s1_last <= up_last;
            end
        end
    end

    // The activation is evaluated on the S1 registers, so mode/shift travel with their beat.
    for (genvar g = 0; g < LANES; g++) begin : g_lane
        relu_lane #(
            .NUM_WIDTH (NUM_WIDTH),
            .FRAC_BITS (FRAC_BITS)
        ) u_lane (
            .x      (s1_data[g*NUM_WIDTH +: NUM_WIDTH]),
            .mode   (s1_mode),
            .sh     (s1_sh),
            .y      (act_bus[g*NUM_WIDTH +: NUM_WIDTH]),
            .is_neg (lane_neg[g])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
            s2_last  <= 1'b0;
        end else if (s2_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= act_bus;
                s2_last <= s1_last;
            end
        end
    end

    assign dn_valid = s2_valid;
    assign dn_data  = s2_data;
    assign dn_last  = s2_last;

`ifdef RELU_STATS_EN
    logic [STAT_WIDTH-1:0] beat_neg;
    logic [STAT_WIDTH-1:0] cnt_q;

    always_comb begin
        beat_neg = '0;
        for (int i = 0; i < LANES; i++) begin
            beat_neg = beat_neg + STAT_WIDTH'(lane_neg[i]);
        end
    end

    // Counted as the beat enters S2, so the value on the port covers the beat being presented;
    // s2_last still flags the previous beat, and a new frame starts after a last beat.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (s1_valid && s2_adv) begin
            cnt_q <= (s2_last ? '0 : cnt_q) + beat_neg;
        end
    end

    assign neg_count = cnt_q;
`else
    logic unused_neg;
    assign unused_neg = ^lane_neg;
    assign neg_count  = '0;
`endif

endmodule

// File: tb/tb_relu_array.sv
// Directed bench for relu_array: vector table for single beats, hand sequences for stalls,
// mode switching, mid-stream reset and the frame negative-element counter.
module tb_relu_array;

    localparam logic [1:0] M_BYP = 2'b00;
    localparam logic [1:0] M_RELU = 2'b01;
    localparam logic [1:0] M_LEAKY = 2'b10;
    localparam logic [1:0] M_CLAMP = 2'b11;

    logic        clk;
    logic        rst_n;
    logic [1:0]  mode;
    logic [3:0]  leaky_sh;
    logic        up_valid;
    logic        up_ready;
    logic [63:0] up_data;
    logic        up_last;
    logic        dn_valid;
    logic        dn_ready;
    logic [63:0] dn_data;
    logic        dn_last;
    logic [31:0] neg_count;

    int n_checks = 0;
    int n_fail   = 0;

    relu_array #(
        .NUM_WIDTH  (16),
        .LANES      (4),
        .FRAC_BITS  (8),
        .STAT_WIDTH (32)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode      (mode),
        .leaky_sh  (leaky_sh),
        .up_valid  (up_valid),
        .up_ready  (up_ready),
        .up_data   (up_data),
        .up_last   (up_last),
        .dn_valid  (dn_valid),
        .dn_ready  (dn_ready),
        .dn_data   (dn_data),
        .dn_last   (dn_last),
        .neg_count (neg_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        string       name;
        logic [1:0]  m;
        logic [3:0]  sh;
        logic [63:0] d;
        logic [63:0] e;
    } vec_t;

    vec_t vt[8];

    // Stream description shared by the multi-beat sequences.
    logic [63:0] s_dat[$];
    logic [63:0] s_exp[$];
    logic        s_lst[$];
    logic [1:0]  s_mode[$];
    int          s_cnt[$];
    int          m_acc;
    logic        m_prev_last;

    task automatic clear_stream();
        s_dat.delete(); s_exp.delete(); s_lst.delete(); s_mode.delete(); s_cnt.delete();
        m_acc = 0;
        m_prev_last = 1'b0;
    endtask

    task automatic push_beat(input logic [63:0] d, input logic l, input logic [1:0] m);
        logic [63:0] e;
        int neg;
        e = d;
        neg = 0;
        for (int k = 0; k < 4; k++) begin
            if (d[k*16+15]) begin
                neg++;
                if (m == M_RELU) e[k*16 +: 16] = 16'h0000;
            end
        end
        m_acc = (m_prev_last ? 0 : m_acc) + neg;
        m_prev_last = l;
        s_dat.push_back(d); s_exp.push_back(e); s_lst.push_back(l);
        s_mode.push_back(m); s_cnt.push_back(m_acc);
    endtask

    function automatic logic [63:0] pat(input int i);
        logic [15:0] l0, l1, l2, l3;
        l0 = 16'h0100 + 16'(i);
        l1 = 16'hFF00 - 16'(i);
        l2 = 16'h0010 * 16'(i);
        l3 = 16'h8000 + 16'(i);
        return {l3, l2, l1, l0};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        up_valid = 1'b0;
        dn_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic send_one(input logic [1:0] m, input logic [3:0] sh, input logic [63:0] d,
                            output logic [63:0] got, output int lat);
        int n;
        @(posedge clk); #1;
        mode = m; leaky_sh = sh; up_data = d; up_last = 1'b1; up_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!up_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk); #1;
        up_valid = 1'b0;
        lat = 0;
        got = 'x;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (dn_valid) begin
                got = dn_data;
                break;
            end
        end
    endtask

    task automatic run_stream(input bit toggle, input string tag);
        int   sent, rcvd, n;
        bit   fire, stall;
        logic [63:0] held;
        n = s_dat.size();
        sent = 0; rcvd = 0; stall = 1'b0; held = '0;
        @(posedge clk); #1;
        dn_ready = 1'b1; leaky_sh = 4'd0;
        up_valid = 1'b1; up_data = s_dat[0]; up_last = s_lst[0]; mode = s_mode[0];
        for (int cyc = 0; cyc < 200 && rcvd < n; cyc++) begin
            @(negedge clk);
            fire = up_valid && up_ready;
            if (stall) chk({tag, "_hold"}, dn_data, held);
            if (dn_valid && dn_ready) begin
                chk({tag, "_data"}, dn_data, s_exp[rcvd]);
                chk({tag, "_last"}, 64'(dn_last), 64'(s_lst[rcvd]));
`ifdef RELU_STATS_EN
                chk({tag, "_negcnt"}, 64'(neg_count), 64'(s_cnt[rcvd]));
`else
                chk({tag, "_negcnt_tied"}, 64'(neg_count), 64'd0);
`endif
                rcvd++;
            end
            stall = dn_valid && !dn_ready;
            held  = dn_data;
            @(posedge clk); #1;
            if (fire) begin
                sent++;
                if (sent < n) begin
                    up_data = s_dat[sent]; up_last = s_lst[sent]; mode = s_mode[sent];
                end else begin
                    up_valid = 1'b0;
                end
            end
            if (toggle) dn_ready = !dn_ready;
        end
        up_valid = 1'b0;
        dn_ready = 1'b1;
        chk({tag, "_beats"}, 64'(rcvd), 64'(n));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [63:0] got;
        int          lat;
        int          leftover;

        vt[0] = '{"relu_basic",   M_RELU,  4'd0,  64'h7FFF_0000_FFFF_8000, 64'h7FFF_0000_0000_0000};
        vt[1] = '{"leaky_sh2",    M_LEAKY, 4'd2,  64'hFFFF_8000_0010_FFF0, 64'hFFFF_E000_0010_FFFC};
        vt[2] = '{"bypass",       M_BYP,   4'd2,  64'hFFFF_8000_0010_FFF0, 64'hFFFF_8000_0010_FFF0};
        vt[3] = '{"clamp_6",      M_CLAMP, 4'd0,  64'hFF00_05FF_0600_0700, 64'h0000_05FF_0600_0600};
        vt[4] = '{"leaky_sh0",    M_LEAKY, 4'd0,  64'h0000_1234_8000_FFF0, 64'h0000_1234_8000_FFF0};
        vt[5] = '{"clamp_edges",  M_CLAMP, 4'd0,  64'h0601_0000_8000_7FFF, 64'h0600_0000_0000_0600};
        vt[6] = '{"leaky_sh15",   M_LEAKY, 4'd15, 64'hC000_0001_FFFF_8000, 64'hFFFF_0001_FFFF_FFFF};
        vt[7] = '{"relu_mixed",   M_RELU,  4'd0,  64'h0000_7000_FFFE_0001, 64'h0000_7000_0000_0001};

        rst_n = 1'b0; mode = M_BYP; leaky_sh = 4'd0; up_valid = 1'b0;
        up_data = '0; up_last = 1'b0; dn_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_dn_valid", 64'(dn_valid), 64'd0);
        chk("rst_dn_data", dn_data, 64'd0);
        chk("rst_dn_last", 64'(dn_last), 64'd0);
        chk("rst_neg_count", 64'(neg_count), 64'd0);
        rst_n = 1'b1;
        #1;
        chk("rst_up_ready", 64'(up_ready), 64'd1);

        for (int i = 0; i < 8; i++) begin
            send_one(vt[i].m, vt[i].sh, vt[i].d, got, lat);
            chk({vt[i].name, "_data"}, got, vt[i].e);
            chk({vt[i].name, "_latency"}, 64'(lat), 64'd2);
        end

        // Eight beats against a toggling dn_ready.
        do_reset();
        clear_stream();
        for (int i = 0; i < 8; i++) push_beat(pat(i), i == 7, M_BYP);
        run_stream(1'b1, "stall8");

        // RELU for beats 0-3, BYPASS from beat 4 on.
        do_reset();
        clear_stream();
        for (int i = 0; i < 8; i++) push_beat(pat(i), i == 7, (i < 4) ? M_RELU : M_BYP);
        run_stream(1'b0, "modesw");

        // Frame of 3 + 1 negative lanes, then a beat opening the next frame with 2.
        do_reset();
        clear_stream();
        push_beat(64'h0001_8001_FFFF_8000, 1'b0, M_BYP);
        push_beat(64'h0000_FFFE_0002_0001, 1'b1, M_BYP);
        push_beat(64'h0003_8000_0005_FFFF, 1'b0, M_BYP);
        run_stream(1'b0, "frame");

        // Reset with both stages full and downstream stalled.
        do_reset();
        @(posedge clk); #1;
        dn_ready = 1'b0; mode = M_BYP; up_last = 1'b0;
        up_data = 64'h1111_2222_3333_4444; up_valid = 1'b1;
        repeat (4) @(negedge clk);
        chk("mid_full_valid", 64'(dn_valid), 64'd1);
        chk("mid_full_up_ready", 64'(up_ready), 64'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_dn_valid", 64'(dn_valid), 64'd0);
        chk("mid_rst_dn_data", dn_data, 64'd0);
        up_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        dn_ready = 1'b1;
        leftover = 0;
        repeat (5) begin
            @(negedge clk);
            if (dn_valid) leftover++;
        end
        chk("mid_rst_no_leftover", 64'(leftover), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
